// File: rtl/stc_sparse_encoder.sv
// stc_sparse_encoder
// Compresses one dense line of N_IN elements into beats of up to N_OUT
// (value, index) pairs for the sparse tensor core operand path. Holds one
// line at a time; emits max(1, ceil(nnz/N_OUT)) beats per line.
//
// Ports
//   clk, reset      : clock, async active-low reset
//   in_valid/ready  : dense line handshake; in_data element i at [i*DW_DATA +: DW_DATA]
//   out_valid/ready : beat handshake
//   out_val         : lane k value at [k*DW_DATA +: DW_DATA]
//   out_idx         : lane k element index at [k*DW_IDX +: DW_IDX] (stc_crossbar packing)
//   out_mask        : lane k holds a real nonzero
//   out_last        : final beat of the line

// One lane of the beat selector: picks the lowest pending element and
// hands the remaining pending set to the next lane.
module stc_enc_lane #(
  parameter int N_IN   = 32,
  parameter int DW_IDX = 5
) (
  input  logic [N_IN-1:0]   pend_in,
  output logic              hit,
  output logic [DW_IDX-1:0] idx,
  output logic [N_IN-1:0]   pend_out
);
  always_comb begin
    hit = |pend_in;
    idx = '0;
    for (int i = N_IN-1; i >= 0; i--)
      if (pend_in[i]) idx = DW_IDX'(i);
    // clear the lowest set bit
    pend_out = pend_in & (pend_in - N_IN'(1));
  end
endmodule

module stc_sparse_encoder #(
  parameter int N_IN    = 32,
  parameter int N_OUT   = 4,
  parameter int DW_DATA = 8,
  parameter int DW_IDX  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*DW_DATA-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*DW_DATA-1:0]  out_val,
  output logic [N_OUT*DW_IDX-1:0]   out_idx,
  output logic [N_OUT-1:0]          out_mask,
  output logic                      out_last
);
  typedef enum logic {IDLE, EMIT} state_t;

  state_t                         state, state_nxt;
  logic [N_IN-1:0][DW_DATA-1:0]   line_buf, in_line;
  logic [N_IN-1:0]                pend, in_nz;
  logic [N_OUT:0][N_IN-1:0]       chain;
  logic                           last;

  assign in_line = in_data;

  for (genvar i = 0; i < N_IN; i++) begin : g_nz
    assign in_nz[i] = |in_line[i];
  end

  // Lanes peel off pending bits lowest-first, so lane order equals index order.
  assign chain[0] = pend;
  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    logic              hit;
    logic [DW_IDX-1:0] idx;
    stc_enc_lane #(.N_IN(N_IN), .DW_IDX(DW_IDX)) u_lane (
      .pend_in  (chain[k]),
      .hit      (hit),
      .idx      (idx),
      .pend_out (chain[k+1])
    );
    assign out_val[k*DW_DATA +: DW_DATA] = hit ? line_buf[idx] : '0;
    assign out_idx[k*DW_IDX +: DW_IDX]   = idx;
    assign out_mask[k]                   = hit;
  end

  // Nothing left after this beat's lanes means it is the last one; an
  // all-zero line therefore gives a single empty last beat.
  assign last      = (state == EMIT) && (chain[N_OUT] == '0);
  assign out_last  = last;
  assign out_valid = (state == EMIT);
  assign in_ready  = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)          state_nxt = EMIT;
      EMIT: if (out_ready && last) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pend     <= '0;
      line_buf <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        line_buf <= in_line;
        pend     <= in_nz;
      end else if (state == EMIT && out_ready) begin
        pend <= chain[N_OUT];
      end
    end
  end
endmodule
